// File: rtl/board_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_generator                                                          |
// | Builds a random board of distinct lit tiles, shows it for SHOW_CYCLES,   |
// | then holds it valid until acknowledged. Option: BOARDGEN_RESEED_EN       |
// | adds a seed port that reloads the LFSR on an accepted start.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module board_generator #(
  parameter int          BOARD_W     = 16,
  parameter int          SHOW_CYCLES = 100_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         num_tiles,
`ifdef BOARDGEN_RESEED_EN
  input  logic [15:0]        seed,
`endif
  input  logic               board_ack,
  output logic [BOARD_W-1:0] board,
  output logic [BOARD_W-1:0] display,
  output logic               board_valid,
  output logic               busy,
  output logic [5:0]         tiles_placed
);

  localparam int                 c_IDX_W     = $clog2(BOARD_W);
  localparam int                 c_CNT_W     = $clog2(SHOW_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_SHOW_LOAD = c_CNT_W'(SHOW_CYCLES);
  localparam logic [5:0]         c_BOARD_W6  = 6'(BOARD_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_SHOW = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [5:0]         r_tgt;
  logic [c_CNT_W-1:0] r_show_cnt;

  logic               w_feedback;
  logic [15:0]        w_lfsr_shift;
  logic [15:0]        w_lfsr_next;
  logic [c_IDX_W-1:0] w_idx;
  logic [BOARD_W-1:0] w_idx_onehot;
  logic [5:0]         w_num_clamped;
  logic [5:0]         w_placed_inc;

  assign w_feedback   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_shift = {r_lfsr[14:0], w_feedback};
  assign w_idx        = r_lfsr[c_IDX_W-1:0];
  assign w_idx_onehot = BOARD_W'(1) << w_idx;
  assign w_placed_inc = tiles_placed + 6'd1;

`ifdef BOARDGEN_RESEED_EN
  // A zero seed would lock the LFSR, so it falls back to the reset seed.
  always_comb begin
    w_lfsr_next = w_lfsr_shift;
    if (r_state == S_IDLE && start) begin
      w_lfsr_next = (seed == 16'd0) ? LFSR_SEED : seed;
    end
  end
`else
  assign w_lfsr_next = w_lfsr_shift;
`endif

  always_comb begin
    w_num_clamped = num_tiles;
    if (num_tiles == 6'd0) begin
      w_num_clamped = 6'd1;
    end else if (num_tiles > c_BOARD_W6) begin
      w_num_clamped = c_BOARD_W6;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_tgt        <= 6'd0;
      r_show_cnt   <= '0;
      board        <= '0;
      display      <= '0;
      board_valid  <= 1'b0;
      busy         <= 1'b0;
      tiles_placed <= 6'd0;
    end else begin
      r_lfsr <= w_lfsr_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            board        <= '0;
            tiles_placed <= 6'd0;
            r_tgt        <= w_num_clamped;
            busy         <= 1'b1;
            r_state      <= S_GEN;
          end
        end
        S_GEN: begin
          // An already-lit candidate is simply retried with the next LFSR value.
          if (!board[w_idx]) begin
            board        <= board | w_idx_onehot;
            tiles_placed <= w_placed_inc;
            if (w_placed_inc == r_tgt) begin
              display    <= board | w_idx_onehot;
              r_show_cnt <= c_SHOW_LOAD;
              r_state    <= S_SHOW;
            end
          end
        end
        S_SHOW: begin
          if (r_show_cnt == c_CNT_W'(1)) begin
            display     <= '0;
            board_valid <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_HOLD;
          end else begin
            r_show_cnt <= r_show_cnt - c_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (board_ack) begin
            board_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_board_generator                                                       |
// | Randomized rounds checked against a set-based board model.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_board_generator;

  localparam int          BOARD_W = 16;
  localparam int          SHOW    = 8;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              board_ack = 1'b0;
  logic [5:0]        num_tiles = 6'd0;
`ifdef BOARDGEN_RESEED_EN
  logic [15:0]       seed = 16'd0;
`endif
  logic [BOARD_W-1:0] board;
  logic [BOARD_W-1:0] display;
  logic               board_valid;
  logic               busy;
  logic [5:0]         tiles_placed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  board_generator #(
    .BOARD_W    (BOARD_W),
    .SHOW_CYCLES(SHOW),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_tiles   (num_tiles),
`ifdef BOARDGEN_RESEED_EN
    .seed        (seed),
`endif
    .board_ack   (board_ack),
    .board       (board),
    .display     (display),
    .board_valid (board_valid),
    .busy        (busy),
    .tiles_placed(tiles_placed)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Free-running LFSR value as the specification defines it.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr = SEED;
    else       m_lfsr = lfsr_next(m_lfsr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk the LFSR sequence, collecting distinct indices until tgt are lit.
  task automatic predict(input logic [15:0] v0, input int tgt,
                         output logic [15:0] pb, output int len);
    bit          seen[BOARD_W];
    int          cnt;
    logic [15:0] v;
    v = v0; cnt = 0; len = 0; pb = '0;
    foreach (seen[i]) seen[i] = 1'b0;
    while (cnt < tgt && len < 70000) begin
      if (!seen[int'(v[3:0])]) begin
        seen[int'(v[3:0])] = 1'b1;
        cnt++;
      end
      len++;
      v = lfsr_next(v);
    end
    foreach (seen[i]) if (seen[i]) pb[i] = 1'b1;
  endtask

  task automatic run_round(input int n, input logic [15:0] sd, input bit inject,
                           input bit do_ack, output logic [15:0] brd);
    int          tgt, len, cnt, steps;
    logic [15:0] pb, v0;
    tgt = (n == 0) ? 1 : ((n > BOARD_W) ? BOARD_W : n);
    num_tiles = 6'(n);
`ifdef BOARDGEN_RESEED_EN
    seed = sd;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    num_tiles = 6'($urandom_range(0, 63));
    check("busy_on", 32'(busy), 32'd1);
    check("board_clr", 32'(board), 32'd0);
    check("placed_clr", 32'(tiles_placed), 32'd0);
    check("display_gen", 32'(display), 32'd0);
`ifdef BOARDGEN_RESEED_EN
    v0 = (sd == 16'd0) ? SEED : sd;
`else
    v0 = m_lfsr;
    if (sd != sd) v0 = 16'd0;
`endif
    predict(v0, tgt, pb, len);
    for (int i = 0; i < len; i++) begin
      if (inject && i == 0) start = 1'b1;
      step();
      start = 1'b0;
    end
    check("placed_end", 32'(tiles_placed), 32'(tgt));
    check("board_gen", 32'(board), 32'(pb));
    check("display_show", 32'(display), 32'(pb));
    check("busy_show", 32'(busy), 32'd1);
    cnt = 0; steps = 0;
    while (!board_valid && steps < SHOW + 4) begin
      if (display != '0) cnt++;
      if (inject && steps == 2) begin
        start = 1'b1;
        board_ack = 1'b1;
      end
      step();
      start = 1'b0;
      board_ack = 1'b0;
      steps++;
    end
    check("show_len", 32'(cnt), 32'(SHOW));
    check("valid_time", 32'(steps), 32'(SHOW));
    check("valid_hold", 32'(board_valid), 32'd1);
    check("busy_hold", 32'(busy), 32'd0);
    check("display_hold", 32'(display), 32'd0);
    check("board_hold", 32'(board), 32'(pb));
    brd = board;
    if (do_ack) begin
      board_ack = 1'b1;
      step();
      board_ack = 1'b0;
      check("valid_ack", 32'(board_valid), 32'd0);
      check("board_idle", 32'(board), 32'(pb));
    end
  endtask

  initial begin
    logic [15:0] b1, b2;
    int          w;
    repeat (2) @(posedge clk);
    #1;
    check("rst_board", 32'(board), 32'd0);
    check("rst_display", 32'(display), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    check("rst_valid", 32'(board_valid), 32'd0);
    check("rst_placed", 32'(tiles_placed), 32'd0);

    run_round(5, 16'd0, 1'b0, 1'b1, b1);
    repeat ($urandom_range(0, 5)) step();
    run_round(0, 16'd0, 1'b0, 1'b1, b1);
    run_round(40, 16'd0, 1'b1, 1'b1, b1);
    check("board_full", 32'(b1), 32'hFFFF);

    // start and ack on the same edge in HOLD, then a held start relaunches.
    run_round(int'($urandom_range(1, 16)), 16'd0, 1'b0, 1'b0, b1);
    num_tiles = 6'd3;
    start = 1'b1;
    board_ack = 1'b1;
    step();
    board_ack = 1'b0;
    check("same_edge_valid", 32'(board_valid), 32'd0);
    check("same_edge_busy", 32'(busy), 32'd0);
    check("same_edge_board", 32'(board), 32'(b1));
    step();
    start = 1'b0;
    check("relaunch_busy", 32'(busy), 32'd1);
    w = 0;
    while (display == '0 && w < 70000) begin
      step();
      w++;
    end
    check("reach_show", 32'(display != '0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_display", 32'(display), 32'd0);
    check("arst_board", 32'(board), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_placed", 32'(tiles_placed), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    step();
    check("post_rst_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 7)) step();
      run_round(int'($urandom_range(0, 20)), 16'(32'($urandom_range(0, 65535))),
                1'(r % 2), 1'b1, b1);
    end

`ifdef BOARDGEN_RESEED_EN
    run_round(6, 16'h1234, 1'b0, 1'b1, b1);
    repeat ($urandom_range(1, 9)) step();
    run_round(6, 16'h1234, 1'b0, 1'b1, b2);
    check("reseed_repeat", 32'(b2), 32'(b1));
    w = int'($urandom_range(1, 16));
    run_round(w, 16'd0, 1'b0, 1'b1, b1);
    repeat ($urandom_range(1, 9)) step();
    run_round(w, SEED, 1'b0, 1'b1, b2);
    check("reseed_zero", 32'(b1), 32'(b2));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_generator.md
# board_generator

Producer side of the Memory Matrix board path. On `start` it builds a random board of distinct lit tiles and shows it to the player for a fixed time, with the display driven only during that window. It then holds the board valid for the guess-checking logic until that logic acknowledges it. The checking logic consumes the board and the player's guesses; this block writes the board it reads.

## Interface
Parameters:
- `BOARD_W`, default 16: tiles on the board (4x4 grid). Must be a power of two, 4..32.
- `SHOW_CYCLES`, default 100_000_000: cycles the pattern is displayed (2 s at 50 MHz). Must be ≥1.
- `LFSR_SEED`, default 16'hACE1: LFSR value after reset. Must be non-zero.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `start` in 1: level, sampled in IDLE only; begins a new round.
- `num_tiles` in 6: tiles to light, sampled on the accepted `start`.
- `board_ack` in 1: consumer has latched `board`; sampled in HOLD only.
- `board` out BOARD_W: generated pattern. Stable from end of GEN until the next accepted `start`.
- `display` out BOARD_W: equals `board` in SHOW, otherwise all zero.
- `board_valid` out 1: high in HOLD only.
- `busy` out 1: high in GEN and SHOW.
- `tiles_placed` out 6: tiles set so far in the current board.

All outputs reset to 0.

## Operation
- LFSR:
  - 16-bit Fibonacci, shifts left every cycle in every state.
  - Feedback `l[15]^l[13]^l[12]^l[10]` goes into bit 0.
  - Reset loads `LFSR_SEED`. The LFSR never holds zero.
- Target count `tgt`:
  - Latched on `start` as `num_tiles`.
  - 0 is treated as 1; values above `BOARD_W` are clamped to `BOARD_W`.
- States:
  - IDLE:
    - `start` → GEN.
    - Clears `board` and `tiles_placed`, latches `tgt`.
  - GEN:
    - Each cycle, candidate index `idx = lfsr[log2(BOARD_W)-1:0]`.
    - If `board[idx]==0`: set it and increment `tiles_placed`. Otherwise no change (retry next cycle).
    - When the increment makes `tiles_placed == tgt` → SHOW next cycle.
  - SHOW:
    - `display = board` for exactly SHOW_CYCLES cycles, counted by a down-counter loaded on entry.
    - Then → HOLD.
  - HOLD:
    - `board_valid=1`, `display=0`.
    - `board_ack` → IDLE; `board` keeps its value in IDLE.
- Simultaneous events and boundaries:
  - `start` outside IDLE is ignored; no queueing.
  - `board_ack` outside HOLD is ignored.
  - `start` and `board_ack` both high in HOLD: ack is taken and the FSM goes to IDLE. `start` must still be high in IDLE to launch a new round.
  - `tgt == BOARD_W`: GEN terminates with `board` all ones. The maximal-length LFSR guarantees every index appears.
  - Reset mid-operation returns to IDLE with all outputs 0 within the same cycle (asynchronous).

## Timing
- `start` high at edge N in IDLE: GEN from N+1, `busy` high from N+1.
- GEN length is at least `tgt` cycles and is unbounded by spec. The LFSR period (65535) makes termination certain.
- The last tile is set at edge M: SHOW from M+1, `display` non-zero cycles M+1..M+SHOW_CYCLES.
- HOLD from M+SHOW_CYCLES+1: `board_valid` rises there, `busy` falls there.
- `board_ack` at edge K in HOLD: `board_valid` low from K+1.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `BOARDGEN_RESEED_EN`:
  - Defined: adds input port `seed[15:0]`. On an accepted `start`, the LFSR loads `seed` instead of shifting; a zero `seed` loads `LFSR_SEED`. Boards are reproducible per seed.
  - Undefined: no `seed` port. The LFSR runs freely from reset, so board content depends on when `start` is pressed.

## Test plan
- Reset, then `num_tiles=5` and `start` pulse → `busy` next cycle; HOLD reached with popcount(`board`)=5 and `tiles_placed`=5; `display` non-zero for exactly SHOW_CYCLES cycles (bench `SHOW_CYCLES=8`).
- `num_tiles=0`, then `num_tiles=40` with `BOARD_W=16` → popcount 1, then `board==16'hFFFF` with `tiles_placed=16`.
- `start` pulsed during GEN and SHOW → no restart, `board` unchanged; `board_ack` pulsed during SHOW → ignored, `board_valid` still rises.
- In HOLD, `start`+`board_ack` on the same edge → IDLE, `board_valid=0`; `start` held one more cycle → new round begins.
- `reset` asserted mid-SHOW between clock edges → `display`, `board`, `busy`, `tiles_placed` zero immediately; FSM in IDLE after release.
- With `BOARDGEN_RESEED_EN`: two rounds with `seed=16'h1234`, `num_tiles=6` → identical `board` both times; `seed=0` gives the same board as `seed=LFSR_SEED`.
